// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings and the
// EX-stage instruction codes that raise a divide request.
package div_iter_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    // Function codes the requester decodes to drive start.
    localparam logic [5:0] INST_DIV  = 6'b011010;
    localparam logic [5:0] INST_DIVU = 6'b011011;

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider with start/done handshake.
// Computes signed or unsigned quotient/remainder in WIDTH iterations plus a sign-fix cycle.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       r_state;
    div_state_e       w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_dvd_raw;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic             w_accept;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_dvs_zero;
    logic [WIDTH-1:0] w_fix_q;
    logic [WIDTH-1:0] w_fix_r;

    assign w_accept  = (r_state == DIV_IDLE) && start && !flush;
    assign w_dvd_neg = is_signed && dividend[WIDTH-1];
    assign w_dvs_neg = is_signed && divisor[WIDTH-1];
    assign w_dvd_abs = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_abs = w_dvs_neg ? -divisor : divisor;

    // The kept remainder is always below |divisor|, so only the shifted/trial
    // value needs the extra bit; its MSB is the borrow of the trial subtract.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_dvs};
    assign w_dvs_zero = (r_dvs == '0);
    assign w_fix_q    = r_q_neg ? -r_quo : r_quo;
    assign w_fix_r    = r_r_neg ? -r_rem : r_rem;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next is defaulted before the case so no path leaves it unassigned
    // (which would infer a latch).
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            DIV_IDLE: if (w_accept) w_next = DIV_CALC;
            DIV_CALC: if (r_cnt == '0) w_next = DIV_FIX;
            DIV_FIX:  w_next = DIV_DONE;
            DIV_DONE: w_next = DIV_IDLE;
            default:  w_next = DIV_IDLE;
        endcase
        if (flush) w_next = DIV_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_dvd_raw   <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_busy <= (w_next != DIV_IDLE);
            r_done <= (w_next == DIV_DONE);

            unique case (r_state)
                DIV_IDLE: begin
                    if (w_accept) begin
                        r_quo     <= w_dvd_abs;
                        r_dvs     <= w_dvs_abs;
                        r_dvd_raw <= dividend;
                        r_q_neg   <= w_dvd_neg ^ w_dvs_neg;
                        r_r_neg   <= w_dvd_neg;
                        r_rem     <= '0;
                        r_cnt     <= CW'(WIDTH - 1);
                    end
                end
                DIV_CALC: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                end
                DIV_FIX: begin
                    // A flushed op must leave the previous results untouched.
                    if (!flush) begin
                        r_dbz <= w_dvs_zero;
                        if (w_dvs_zero) begin
                            r_quotient  <= '1;
                            r_remainder <= r_dvd_raw;
                        end else begin
                            r_quotient  <= w_fix_q;
                            r_remainder <= w_fix_r;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed corner cases plus a randomized
// sweep against an arithmetic reference model.
module tb_div_iter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    div_iter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .start      (start),
        .is_signed  (is_signed),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: plain integer division; divide-by-zero returns all ones and the raw dividend.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        longint sa;
        longint sb;
        sa = $signed(a);
        sb = $signed(b);
        z  = (b == '0);
        if (z) begin
            q = '1;
            r = a;
        end else if (s) begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Runs one divide from the cycle after the previous one; optionally pulses
    // start with junk operands at cycles 5 and 20 of the operation.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit noise, output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z);
        int lat;
        int busy_low;
        lat      = -1;
        busy_low = 0;
        @(posedge clk); #1;
        check("idle_before_start", {62'd0, busy, done}, 64'd0);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        for (int n = 1; n <= W + 10; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (noise && (n == 5 || n == 20)) begin
                start     = 1'b1;
                dividend  = W'($urandom);
                divisor   = W'($urandom);
                is_signed = 1'($urandom_range(0, 1));
            end
            if (!busy) busy_low++;
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        check("latency", 64'(lat), 64'(W + 2));
        check("busy_during_op", 64'(busy_low), 64'd0);
        q = quotient;
        r = remainder;
        z = div_by_zero;
    endtask

    task automatic div_expect(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic s, input bit noise, input logic [W-1:0] eq,
                              input logic [W-1:0] er, input logic ez);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        run_op(a, b, s, noise, q, r, z);
        check({tag, "_q"}, 64'(q), 64'(eq));
        check({tag, "_r"}, 64'(r), 64'(er));
        check({tag, "_dbz"}, 64'(z), 64'(ez));
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ez;
        int           cnt_done;
        int           cnt_busy;

        rst = 1'b1; flush = 1'b0; start = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, div_by_zero, quotient, remainder},
              {3'b000, 32'd0, 32'd0});
        rst = 1'b0;

        div_expect("u100_7", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32'd2, 1'b0);
        div_expect("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        div_expect("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd1, 1'b0);
        div_expect("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 1'b0);
        div_expect("u_dbz", 32'h1234_5678, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        div_expect("s_dbz", 32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
        div_expect("u_big", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0);
        div_expect("u100_7b", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32'd2, 1'b0);

        // Flush at cycle 10: busy drops at 11, no done, results stay 14/2.
        @(posedge clk); #1;
        dividend = 32'd999; divisor = 32'd10; is_signed = 1'b0; start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy_low", 64'(busy), 64'd0);
        cnt_done = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) cnt_done++;
        end
        check("flush_no_done", 64'(cnt_done), 64'd0);
        check("flush_keep_q", 64'(quotient), 64'd14);
        check("flush_keep_r", 64'(remainder), 64'd2);

        // start and flush together: the request is dropped.
        start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        cnt_done = 0;
        cnt_busy = 0;
        for (int n = 0; n < 40; n++) begin
            if (busy) cnt_busy++;
            if (done) cnt_done++;
            @(posedge clk); #1;
        end
        check("startflush_busy", 64'(cnt_busy), 64'd0);
        check("startflush_done", 64'(cnt_done), 64'd0);

        // Ignored starts mid-operation, then an immediate back-to-back op.
        div_expect("noise_op", 32'd1000, 32'd33, 1'b0, 1'b1, 32'd30, 32'd10, 1'b0);
        div_expect("b2b_op", 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);

        // Reset at cycle 15 of an operation clears everything.
        @(posedge clk); #1;
        dividend = 32'd12345; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_outputs", {busy, done, div_by_zero, quotient, remainder},
              {3'b000, 32'd0, 32'd0});
        div_expect("after_rst", 32'd12345, 32'd3, 1'b0, 1'b0, 32'd4115, 32'd0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: b = 32'd1;
                1: a = '0;
                2: begin a = W'($urandom_range(0, 255)); b = b | 32'h0001_0000; end
                3: b = '0;
                4: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                5: begin a = W'($urandom_range(0, 2000)) - 32'd1000;
                          b = W'($urandom_range(0, 40)) - 32'd20; end
                default: ;
            endcase
            run_op(a, b, s, 1'b0, q, r, z);
            ref_div(a, b, s, eq, er, ez);
            check("rand_q", 64'(q), 64'(eq));
            check("rand_r", 64'(r), 64'(er));
            check("rand_dbz", 64'(z), 64'(ez));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
